// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box, round/key widths and key-schedule FSM states.
package present_pkg;

  localparam int unsigned PRESENT_ROUNDS  = 31;
  localparam int unsigned ROUND_KEY_WIDTH = 64;
  localparam int unsigned RC_WIDTH        = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/present_key_update.sv
// One PRESENT key-register update step (80- or 128-bit variant), purely combinational.
module present_key_update
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [RC_WIDTH-1:0]  rc_i,
  output logic [KEY_WIDTH-1:0] key_o
);

  logic [KEY_WIDTH-1:0] rot;

  // Left rotation by 61.
  assign rot = {key_i[KEY_WIDTH-62:0], key_i[KEY_WIDTH-1:KEY_WIDTH-61]};

  if (KEY_WIDTH == 128) begin : g_k128
    always_comb begin
      key_o          = rot;
      key_o[127:124] = sbox(rot[127:124]);
      key_o[123:120] = sbox(rot[123:120]);
      key_o[66:62]   = rot[66:62] ^ rc_i;
    end
  end else begin : g_k80
    always_comb begin
      key_o        = rot;
      key_o[79:76] = sbox(rot[79:76]);
      key_o[19:15] = rot[19:15] ^ rc_i;
    end
  end

endmodule

// File: rtl/present_key_schedule.sv
// Sequential PRESENT key scheduler with valid/ready round-key output.
// Optional outRoundIdx port enabled by defining PRESENT_KEYSCHED_TAG_EN.
module present_key_schedule
  import present_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 80,
  parameter int unsigned ROUNDS    = PRESENT_ROUNDS
) (
  input  logic                 inClk,
  input  logic                 inRstN,
  input  logic [KEY_WIDTH-1:0] inKey,
  input  logic                 inKeyValid,
  output logic                 outKeyReady,
  output logic [63:0]          outRoundKey,
  output logic                 outRoundKeyValid,
  input  logic                 inRoundKeyReady,
  output logic                 outBusy,
  output logic                 outDone
`ifdef PRESENT_KEYSCHED_TAG_EN
  ,
  output logic [4:0]           outRoundIdx
`endif
);

  if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_width
    $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_key_schedule: ROUNDS must be in 1..31");
  end

  localparam logic [RC_WIDTH-1:0] LAST_IDX = RC_WIDTH'(ROUNDS);

  ks_state_e            state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d, key_next;
  logic [RC_WIDTH-1:0]  rc_q, rc_d;
  logic [RC_WIDTH-1:0]  idx_q, idx_d;
  logic                 done_q, done_d;

  present_key_update #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_update (
    .key_i(key_q),
    .rc_i (rc_q),
    .key_o(key_next)
  );

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rc_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (inKeyValid) begin
          key_d   = inKey;
          rc_d    = RC_WIDTH'(1);
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (inRoundKeyReady) begin
          if (idx_q == LAST_IDX) begin
            // Zeroise key material once the last round key is consumed.
            key_d   = '0;
            rc_d    = '0;
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            key_d = key_next;
            rc_d  = rc_q + RC_WIDTH'(1);
            idx_d = idx_q + RC_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign outKeyReady      = (state_q == ST_IDLE);
  assign outRoundKeyValid = (state_q == ST_RUN);
  assign outBusy          = (state_q == ST_RUN);
  assign outDone          = done_q;
  assign outRoundKey      = key_q[KEY_WIDTH-1 -: ROUND_KEY_WIDTH];
`ifdef PRESENT_KEYSCHED_TAG_EN
  assign outRoundIdx      = idx_q;
`endif

endmodule

// File: tb/tb_present_key_schedule.sv
// Self-checking bench for present_key_schedule: 80/128-bit and short-schedule instances.
module tb_present_key_schedule;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef struct {
    int unsigned idx;
    logic [63:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 80-bit, 31 rounds
  logic [79:0]  a_key;
  logic         a_kv, a_kr, a_rkv, a_rr, a_busy, a_done;
  logic [63:0]  a_rk;
  // 128-bit, 31 rounds
  logic [127:0] b_key;
  logic         b_kv, b_kr, b_rkv, b_rr, b_busy, b_done;
  logic [63:0]  b_rk;
  // 80-bit, 3 rounds
  logic [79:0]  c_key;
  logic         c_kv, c_kr, c_rkv, c_rr, c_busy, c_done;
  logic [63:0]  c_rk;
`ifdef PRESENT_KEYSCHED_TAG_EN
  logic [4:0]   a_idx, b_idx, c_idx;
`endif

  logic [63:0] got [32];

  present_key_schedule #(.KEY_WIDTH(80), .ROUNDS(31)) u_a (
    .inClk(clk), .inRstN(rst_n), .inKey(a_key), .inKeyValid(a_kv),
    .outKeyReady(a_kr), .outRoundKey(a_rk), .outRoundKeyValid(a_rkv),
    .inRoundKeyReady(a_rr), .outBusy(a_busy), .outDone(a_done)
`ifdef PRESENT_KEYSCHED_TAG_EN
    , .outRoundIdx(a_idx)
`endif
  );

  present_key_schedule #(.KEY_WIDTH(128), .ROUNDS(31)) u_b (
    .inClk(clk), .inRstN(rst_n), .inKey(b_key), .inKeyValid(b_kv),
    .outKeyReady(b_kr), .outRoundKey(b_rk), .outRoundKeyValid(b_rkv),
    .inRoundKeyReady(b_rr), .outBusy(b_busy), .outDone(b_done)
`ifdef PRESENT_KEYSCHED_TAG_EN
    , .outRoundIdx(b_idx)
`endif
  );

  present_key_schedule #(.KEY_WIDTH(80), .ROUNDS(3)) u_c (
    .inClk(clk), .inRstN(rst_n), .inKey(c_key), .inKeyValid(c_kv),
    .outKeyReady(c_kr), .outRoundKey(c_rk), .outRoundKeyValid(c_rkv),
    .inRoundKeyReady(c_rr), .outBusy(c_busy), .outDone(c_done)
`ifdef PRESENT_KEYSCHED_TAG_EN
    , .outRoundIdx(c_idx)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: round keys K1..K32 from the textbook key-register update.
  task automatic model80(input logic [79:0] key, output logic [63:0] ks [32]);
    logic [79:0] k;
    k = key;
    for (int i = 0; i < 32; i++) begin
      ks[i] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = SB[k[79:76]];
      k = k ^ (80'(i + 1) << 15);
    end
  endtask

  task automatic model128(input logic [127:0] key, output logic [63:0] ks [32]);
    logic [127:0] k;
    k = key;
    for (int i = 0; i < 32; i++) begin
      ks[i] = k[127:64];
      k = (k << 61) | (k >> 67);
      k[127:124] = SB[k[127:124]];
      k[123:120] = SB[k[123:120]];
      k = k ^ (128'(i + 1) << 62);
    end
  endtask

  // Full schedule on u_a. hold: keep inKeyValid high with key2 during RUN.
  task automatic run80(input logic [79:0] key, input bit rnd, input bit hold, input logic [79:0] key2);
    logic [63:0] exp [32];
    logic [63:0] prev;
    bit stall;
    int unsigned n, cyc;
    model80(key, exp);
    @(negedge clk);
    chk("idle_key_ready", a_kr, 1);
    a_key = key; a_kv = 1'b1; a_rr = 1'b0;
    @(negedge clk);
    if (hold) a_key = key2; else a_kv = 1'b0;
    chk("busy_in_run", a_busy, 1);
    n = 0; cyc = 0; stall = 0; prev = '0;
    while (n < 32 && cyc < 400) begin
      if (!a_rkv) begin
        chk("valid_in_run", a_rkv, 1);
        break;
      end
      if (stall) chk("stall_stable", a_rk, prev);
      a_rr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_rr) begin
        chk($sformatf("k80_%0d", n + 1), a_rk, exp[n]);
`ifdef PRESENT_KEYSCHED_TAG_EN
        chk("k80_idx", a_idx, n);
`endif
        got[n] = a_rk;
        n++;
        stall = 0;
      end else begin
        stall = 1;
        prev = a_rk;
      end
      cyc++;
      @(negedge clk);
    end
    if (n < 32) chk("schedule_timeout", n, 32);
    if (!rnd) chk("consecutive_cycles", cyc, 32);
    a_rr = 1'b0;
    chk("done_pulse", a_done, 1);
    chk("done_key_ready", a_kr, 1);
    chk("done_valid_low", a_rkv, 0);
    chk("done_key_zero", a_rk, 0);
    @(negedge clk);
    if (hold) begin
      a_kv = 1'b0;
      chk("reload_valid", a_rkv, 1);
      chk("reload_k1", a_rk, key2[79:16]);
    end
    chk("done_one_cycle", a_done, 0);
  endtask

  task automatic run128(input logic [127:0] key);
    logic [63:0] exp [32];
    model128(key, exp);
    @(negedge clk);
    b_key = key; b_kv = 1'b1;
    @(negedge clk);
    b_kv = 1'b0; b_rr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("k128_valid", b_rkv, 1);
      chk($sformatf("k128_%0d", i + 1), b_rk, exp[i]);
      @(negedge clk);
    end
    b_rr = 1'b0;
    chk("k128_done", b_done, 1);
    chk("k128_ready", b_kr, 1);
  endtask

  initial begin
    vec_t tbl [6];
    logic [63:0] e2 [32];
    logic [63:0] e3 [32];
    logic [79:0] k2, k3;

    rst_n = 1'b0;
    a_key = '0; a_kv = 0; a_rr = 0;
    b_key = '0; b_kv = 0; b_rr = 0;
    c_key = '0; c_kv = 0; c_rr = 0;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", a_kr, 1);
    chk("rst_valid", a_rkv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_round_key", a_rk, 0);
`ifdef PRESENT_KEYSCHED_TAG_EN
    chk("rst_idx", a_idx, 0);
`endif
    rst_n = 1'b1;

    // All-zero 80-bit key with published round keys.
    tbl[0] = '{0,  64'h0000000000000000};
    tbl[1] = '{1,  64'hC000000000000000};
    tbl[2] = '{2,  64'h5000180000000001};
    tbl[3] = '{3,  64'h60000A0003000001};
    tbl[4] = '{0,  64'h0000000000000000};
    tbl[5] = '{1,  64'hC000000000000000};
    run80(80'h0, 1'b0, 1'b0, 80'h0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tbl80_k%0d", tbl[i].idx + 1), got[tbl[i].idx], tbl[i].exp);

    // All-zero 128-bit key, then a random one.
    run128(128'h0);
    chk("tbl128_k1", got[0] ^ 64'h0, tbl[4].exp);
    run128({$urandom, $urandom, $urandom, $urandom});

    // Random key under random backpressure must match the unstalled model.
    run80({$urandom, $urandom, 16'($urandom)}, 1'b1, 1'b0, 80'h0);

    // Key valid held high through RUN with a different key.
    k2 = {$urandom, $urandom, 16'($urandom)};
    run80({$urandom, $urandom, 16'($urandom)}, 1'b0, 1'b1, k2);

    // Second schedule is now running; reset it while K10 is presented.
    model80(k2, e2);
    a_rr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("k2_%0d", i + 1), a_rk, e2[i]);
      @(negedge clk);
    end
    chk("k2_10", a_rk, e2[9]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; a_rr = 1'b0;
    chk("midrst_key_ready", a_kr, 1);
    chk("midrst_valid", a_rkv, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_done", a_done, 0);
    chk("midrst_round_key", a_rk, 0);
`ifdef PRESENT_KEYSCHED_TAG_EN
    chk("midrst_idx", a_idx, 0);
`endif
    @(negedge clk);
    chk("midrst_no_done", a_done, 0);
    run80({$urandom, $urandom, 16'($urandom)}, 1'b0, 1'b0, 80'h0);

    // Short schedule: ROUNDS=3 gives 4 keys.
    k3 = {$urandom, $urandom, 16'($urandom)};
    model80(k3, e3);
    @(negedge clk);
    c_key = k3; c_kv = 1'b1;
    @(negedge clk);
    c_kv = 1'b0; c_rr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("k3_valid", c_rkv, 1);
      chk($sformatf("k3_%0d", i + 1), c_rk, e3[i]);
`ifdef PRESENT_KEYSCHED_TAG_EN
      chk("k3_idx", c_idx, i);
`endif
      @(negedge clk);
    end
    c_rr = 1'b0;
    chk("k3_done", c_done, 1);
    chk("k3_idle_ready", c_kr, 1);
`ifdef PRESENT_KEYSCHED_TAG_EN
    chk("k3_idle_idx", c_idx, 0);
`endif
    @(negedge clk);
    chk("k3_done_end", c_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
